// File: rtl/mod_acc_stream.sv
// Streaming modular accumulator over the BLS12-381 scalar field: folds a packet of
// field elements into one sum mod M. Optional MOD_ACC_INPUT_REDUCE_EN pre-reduces inputs.
module mod_acc_stream #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0]      out_count
);

  localparam logic [DATA_WIDTH-1:0] M =
    DATA_WIDTH'(256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001);
  localparam logic [DATA_WIDTH:0] M_EXT  = {1'b0, M};
  localparam logic [DATA_WIDTH:0] M2_EXT = M_EXT << 1;

  typedef enum logic {S_ACC = 1'b0, S_OUT = 1'b1} state_t;

  state_t                r_state;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_out_sum;
  logic [CNT_W-1:0]      r_out_count;

  logic [DATA_WIDTH-1:0] w_din;
  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH-1:0] w_sum_sub;
  logic [DATA_WIDTH-1:0] w_modsum;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic                  w_accept;

`ifdef MOD_ACC_INPUT_REDUCE_EN
  // 3M exceeds 2^256, so at most 2M ever needs removing
  always_comb begin
    w_din = in_data;
    if ({1'b0, in_data} >= M2_EXT)
      w_din = in_data - M2_EXT[DATA_WIDTH-1:0];
    else if (in_data >= M)
      w_din = in_data - M;
  end
`else
  assign w_din = in_data;
`endif

  // Conditional-subtract modular adder; both operands are < M
  assign w_sum     = {1'b0, r_acc} + {1'b0, w_din};
  assign w_sum_sub = DATA_WIDTH'(w_sum - M_EXT);
  assign w_modsum  = (w_sum >= M_EXT) ? w_sum_sub : w_sum[DATA_WIDTH-1:0];

  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_accept  = in_valid & r_in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_ACC;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_sum   <= '0;
      r_out_count <= '0;
    end else begin
      case (r_state)
        S_ACC: begin
          if (w_accept) begin
            r_acc <= w_modsum;
            r_cnt <= w_cnt_inc;
            if (in_last) begin
              r_out_sum   <= w_modsum;
              r_out_count <= w_cnt_inc;
              r_state     <= S_OUT;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_state     <= S_ACC;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_ACC;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_count = r_out_count;

endmodule

// File: tb/tb_mod_acc_stream.sv
// Directed bench for mod_acc_stream; a second instance with CNT_W=2 covers saturation.
module tb_mod_acc_stream;

  localparam logic [255:0] M =
    256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_last, out_valid, out_ready;
  logic [255:0] in_data, out_sum;
  logic [15:0]  out_count;

  logic         in_valid2, in_ready2, in_last2, out_valid2, out_ready2;
  logic [255:0] in_data2, out_sum2;
  logic [1:0]   out_count2;

  int n_tests = 0;
  int n_fail  = 0;

  mod_acc_stream #(.DATA_WIDTH(256), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_count(out_count));

  mod_acc_stream #(.DATA_WIDTH(256), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .in_last(in_last2), .out_valid(out_valid2), .out_ready(out_ready2), .out_sum(out_sum2),
    .out_count(out_count2));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [255:0] d, input logic l);
    in_valid = 1'b1; in_data = d; in_last = l;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    n_tests++; if (out_sum !== 256'd0) begin n_fail++; $display("FAIL rst_out_sum got %h exp 0", out_sum); end
    n_tests++; if (out_count !== 16'd0) begin n_fail++; $display("FAIL rst_out_count got %0d exp 0", out_count); end
  endtask

  task automatic test_basic();
    send(256'd5, 1'b0);
    send(256'd7, 1'b0);
    send(256'd9, 1'b1);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b exp 1", out_valid); end
    n_tests++; if (out_sum !== 256'd21) begin n_fail++; $display("FAIL basic_sum got %0d exp 21", out_sum); end
    n_tests++; if (out_count !== 16'd3) begin n_fail++; $display("FAIL basic_count got %0d exp 3", out_count); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_bubble got %b exp 0", in_ready); end
    @(posedge clk); #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_back got %b exp 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop got %b exp 0", out_valid); end
  endtask

  task automatic test_wrap();
    send(M - 256'd1, 1'b0);
    send(256'd2, 1'b1);
    n_tests++; if (out_sum !== 256'd1) begin n_fail++; $display("FAIL wrap1_sum got %h exp 1", out_sum); end
    n_tests++; if (out_count !== 16'd2) begin n_fail++; $display("FAIL wrap1_count got %0d exp 2", out_count); end
    @(posedge clk); #1;
    send(M - 256'd1, 1'b0);
    send(256'd1, 1'b1);
    n_tests++; if (out_sum !== 256'd0) begin n_fail++; $display("FAIL wrap0_sum got %h exp 0", out_sum); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(256'd11, 1'b0);
    send(256'd22, 1'b1);
    in_valid = 1'b1; in_data = 256'd100; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %b exp 0", i, in_ready); end
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d] got %b exp 1", i, out_valid); end
      n_tests++; if (out_sum !== 256'd33) begin n_fail++; $display("FAIL bp_sum[%0d] got %0d exp 33", i, out_sum); end
      n_tests++; if (out_count !== 16'd2) begin n_fail++; $display("FAIL bp_count[%0d] got %0d exp 2", i, out_count); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got %b exp 1", in_ready); end
    send(256'd40, 1'b1);
    n_tests++; if (out_sum !== 256'd40) begin n_fail++; $display("FAIL bp_next_sum got %0d exp 40", out_sum); end
    n_tests++; if (out_count !== 16'd1) begin n_fail++; $display("FAIL bp_next_count got %0d exp 1", out_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    send(256'd3, 1'b0);
    send(256'd4, 1'b0);
    #2 rst = 1'b1;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b exp 0", out_valid); end
    n_tests++; if (out_sum !== 256'd0) begin n_fail++; $display("FAIL rmid_sum got %0d exp 0", out_sum); end
    n_tests++; if (out_count !== 16'd0) begin n_fail++; $display("FAIL rmid_count got %0d exp 0", out_count); end
    @(posedge clk); #1 rst = 1'b0;
    send(256'd10, 1'b1);
    n_tests++; if (out_sum !== 256'd10) begin n_fail++; $display("FAIL rmid_next_sum got %0d exp 10", out_sum); end
    n_tests++; if (out_count !== 16'd1) begin n_fail++; $display("FAIL rmid_next_count got %0d exp 1", out_count); end
    @(posedge clk); #1;
    // reset while a result is pending
    out_ready = 1'b0;
    send(256'd8, 1'b1);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rout_pre_valid got %b exp 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rout_valid got %b exp 0", out_valid); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rout_in_ready got %b exp 1", in_ready); end
    n_tests++; if (out_sum !== 256'd0) begin n_fail++; $display("FAIL rout_sum got %0d exp 0", out_sum); end
    @(posedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 6; i++) begin
      in_valid2 = 1'b1; in_data2 = 256'd1; in_last2 = (i == 5);
      @(posedge clk); #1;
    end
    in_valid2 = 1'b0; in_last2 = 1'b0;
    n_tests++; if (out_valid2 !== 1'b1) begin n_fail++; $display("FAIL sat_valid got %b exp 1", out_valid2); end
    n_tests++; if (out_sum2 !== 256'd6) begin n_fail++; $display("FAIL sat_sum got %0d exp 6", out_sum2); end
    n_tests++; if (out_count2 !== 2'd3) begin n_fail++; $display("FAIL sat_count got %0d exp 3", out_count2); end
    @(posedge clk); #1;
  endtask

`ifdef MOD_ACC_INPUT_REDUCE_EN
  task automatic test_input_reduce();
    logic [255:0] all_ones;
    logic [255:0] exp_red;
    all_ones = '1;
    exp_red  = all_ones - (M << 1);
    send(all_ones, 1'b1);
    n_tests++; if (out_sum !== exp_red) begin n_fail++; $display("FAIL red_max got %h exp %h", out_sum, exp_red); end
    @(posedge clk); #1;
    send(M, 1'b1);
    n_tests++; if (out_sum !== 256'd0) begin n_fail++; $display("FAIL red_m got %h exp 0", out_sum); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    in_valid2 = 1'b0; in_data2 = '0; in_last2 = 1'b0; out_ready2 = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_saturation();
`ifdef MOD_ACC_INPUT_REDUCE_EN
    test_input_reduce();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_acc_stream.md
# mod_acc_stream

Streaming modular accumulator for the BLS12-381 scalar field. It consumes a valid/ready stream of 256-bit field elements, one per cycle, and folds each element into a running sum mod M using the field's conditional-subtract modular adder. When the beat flagged `in_last` is accepted, it presents the packet sum and beat count on a valid/ready output port. It sits downstream of coefficient producers in the polynomial datapath and reduces a coefficient vector to a single field element, for example for evaluation sums and checksum reduction.

## Interface
- `DATA_WIDTH`, 256: field element width; must be 256 for the fixed modulus.
- `CNT_W`, 16: width of the beat counter.
- `M` (localparam), 256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001: field modulus.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `in_valid`, input, 1: input beat valid.
- `in_ready`, output, 1: accumulator can accept a beat.
- `in_data`, input, DATA_WIDTH: field element.
- `in_last`, input, 1: the beat closes the packet.
- `out_valid`, output, 1: result available.
- `out_ready`, input, 1: consumer takes the result.
- `out_sum`, output, DATA_WIDTH: packet sum mod M.
- `out_count`, output, CNT_W: number of beats in the packet, saturating.

## Operation
- Two states.
  - S_ACC: `in_ready`=1, `out_valid`=0.
  - S_OUT: `in_ready`=0, `out_valid`=1.
- Accept condition: `in_valid & in_ready`.
  - On accept: `acc <= modadd(acc, in_data)` and `cnt <= sat(cnt+1)`.
  - `acc` is 0 at the start of every packet.
- modadd(x, y):
  - Form the 257-bit sum s = x + y.
  - If s >= M, the result is s - M; otherwise the result is s.
  - Both operands must be < M. The result is then always < M.
- Accept with `in_last`=1:
  - `out_sum <= modadd(acc, in_data)`.
  - `out_count <= sat(cnt+1)`.
  - Next state is S_OUT.
- S_OUT:
  - `out_sum` and `out_count` stay stable until the handshake.
  - On `out_valid & out_ready`: `acc <= 0`, `cnt <= 0`, next state is S_ACC.
- Counter:
  - Saturates at 2^CNT_W-1; it never wraps.
  - The sum itself is unaffected by saturation.
- Single-beat packet: `out_sum` = `in_data` (reduced if the macro is on), `out_count` = 1.
- An input beat without a preceding `in_last` continues the current packet. There is no timeout.
- `in_data` and `in_last` are ignored when `in_valid`=0 or in S_OUT.

## Timing
- Reset state (asynchronous, immediate):
  - State S_ACC, so `in_ready`=1 once `rst` falls.
  - `out_valid`=0, `out_sum`=0, `out_count`=0, `acc`=0, `cnt`=0.
- Throughput: 1 beat per cycle within a packet.
- Latency: `in_last` accepted at edge t gives `out_valid`=1 after edge t, visible in cycle t+1.
- Packet boundary costs at least 1 bubble:
  - `in_ready`=0 for every cycle `out_valid`=1.
  - If `out_ready`=1 in the first S_OUT cycle, `in_ready` returns to 1 in the next cycle.
- `in_ready` and `out_valid` are decoded from registered state only. Neither depends combinationally on `in_valid` or `out_ready`.
- Reset asserted mid-packet or in S_OUT:
  - The partial sum and any pending result are discarded.
  - Outputs return to reset values asynchronously.
- The modadd path is combinational between the `acc` and `in_data` registers. Single-cycle closure at the target clock is required.

## Configuration
- `MOD_ACC_INPUT_REDUCE_EN`
  - Defined: each accepted `in_data` is first fully reduced into [0, M) by subtracting 2M, M, or nothing, selected by comparison. Any 256-bit input is legal. Timing and latency are unchanged.
  - Undefined: `in_data` feeds modadd directly. Inputs must already be < M; a result for inputs >= M is not specified and not checked.

## Test plan
- Reset, then packet {5, 7, 9(last)}, `out_ready`=1 → `out_valid` one cycle after the third accept; `out_sum`=21, `out_count`=3; `in_ready` low for exactly 1 cycle.
- Packet {M-1, 2(last)} → `out_sum`=1 (wrap). Packet {M-1, 1(last)} → `out_sum`=0.
- `out_ready`=0 held for 5 cycles in S_OUT while `in_valid`=1 → `in_ready`=0 throughout; `out_sum` and `out_count` stable; no beat consumed; the next packet starts from `acc`=0.
- Assert `rst` after 2 beats of {3, 4, 6(last)} → immediate `out_valid`=0, `out_sum`=0, `out_count`=0. The next packet {10(last)} gives `out_sum`=10, `out_count`=1.
- With `CNT_W`=2, a 6-beat packet of value 1 → `out_sum`=6, `out_count`=3 (saturated).
- With `MOD_ACC_INPUT_REDUCE_EN` defined, packet {2^256-1(last)} → `out_sum`=(2^256-1) mod M, i.e. 2^256-1-2M.
